// File: rtl/axis_stream_checker_pkg.sv
// axis_stream_checker_pkg: shared FSM encoding and LFSR taps for the stream checker
package axis_stream_checker_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_IN_FRAME = 1'b1} state_t;
  // x^16+x^14+x^13+x^11, left-shifting Fibonacci form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/axis_stream_checker_if.sv
// axis_stream_checker_if: AXI4-Stream handshake/data bundle with source and sink views
interface axis_stream_checker_if #(parameter int WIDTH = 32);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [WIDTH-1:0] tdata;
  logic [WIDTH/8-1:0] tstrb;
  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/axis_stream_checker_lfsr16.sv
// axis_lfsr16: free-running 16-bit Fibonacci LFSR, shared by sink throttling and source models
module axis_lfsr16
  import axis_stream_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic        bit0
);
  logic [15:0] r_lfsr;
  always_ff @(posedge clk)
    r_lfsr <= rst ? seed : {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  assign bit0 = r_lfsr[0];
endmodule

// File: rtl/axis_stream_checker.sv
// axis_stream_checker: AXI4-Stream sink checking frame length, data continuity and strobes
module axis_stream_checker
  import axis_stream_checker_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          FRAME_LEN = 1024,
  parameter int          CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_areset,
  axis_stream_checker_if.slave  s00_axis,
  input  logic                  cfg_throttle,
  input  logic                  cfg_check_seq,
  input  logic                  clear_stats,
  output logic [CNT_W-1:0]      beat_count,
  output logic [CNT_W-1:0]      frame_count,
  output logic [CNT_W-1:0]      len_err_count,
  output logic [CNT_W-1:0]      seq_err_count,
  output logic [CNT_W-1:0]      strb_err_count,
  output logic                  err_sticky,
  output logic                  in_frame
);
  localparam int IDX_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [WIDTH/8-1:0] STRB_ALL = '1;
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_ovr;
  logic [WIDTH-1:0] r_exp;
  logic             r_tready;
  logic             w_lfsr0;
  logic             w_acc;
  logic             w_at_last;
  logic             w_len_err;
  logic             w_seq_err;
  logic             w_strb_err;
  axis_lfsr16 u_lfsr (
    .clk  (s00_axis_aclk),
    .rst  (s00_axis_areset),
    .seed (LFSR_SEED),
    .bit0 (w_lfsr0)
  );
  assign w_acc      = s00_axis.tvalid & r_tready;
  assign w_at_last  = r_idx == IDX_LAST;
  // r_ovr limits an overrun to one count until the frame finally closes
  assign w_len_err  = w_acc & (s00_axis.tlast ? !w_at_last : w_at_last & !r_ovr);
  assign w_seq_err  = w_acc & cfg_check_seq & (r_state == ST_IN_FRAME) & (s00_axis.tdata != r_exp);
  assign w_strb_err = w_acc & (s00_axis.tstrb != STRB_ALL);
  assign s00_axis.tready = r_tready;
  assign in_frame   = r_state == ST_IN_FRAME;
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_ovr    <= 1'b0;
      r_exp    <= '0;
      r_tready <= 1'b0;
    end else begin
      r_tready <= cfg_throttle ? w_lfsr0 : 1'b1;
      if (w_acc) begin
        r_state <= s00_axis.tlast ? ST_IDLE : ST_IN_FRAME;
        r_idx   <= s00_axis.tlast ? '0 : w_at_last ? r_idx : r_idx + 1'b1;
        r_ovr   <= !s00_axis.tlast & (r_ovr | w_at_last);
        // rebasing on every beat turns a single bad word into at most two errors
        if (cfg_check_seq) r_exp <= s00_axis.tdata + 1'b1;
      end
    end
  end
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc, input logic clr);
    return clr ? CNT_W'(inc) : c + CNT_W'(inc & ~&c);
  endfunction
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      beat_count     <= '0;
      frame_count    <= '0;
      len_err_count  <= '0;
      seq_err_count  <= '0;
      strb_err_count <= '0;
      err_sticky     <= 1'b0;
    end else begin
      beat_count     <= bump(beat_count, w_acc, clear_stats);
      frame_count    <= bump(frame_count, w_acc & s00_axis.tlast, clear_stats);
      len_err_count  <= bump(len_err_count, w_len_err, clear_stats);
      seq_err_count  <= bump(seq_err_count, w_seq_err, clear_stats);
      strb_err_count <= bump(strb_err_count, w_strb_err, clear_stats);
      err_sticky     <= (err_sticky & !clear_stats) | w_len_err | w_seq_err | w_strb_err;
    end
  end
endmodule

// File: tb/tb_axis_stream_checker.sv
// tb_axis_stream_checker: directed self-checking bench for axis_stream_checker
module tb_axis_stream_checker;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic thr = 1'b0;
  logic seqen = 1'b1;
  logic clr = 1'b0;
  logic [31:0] beat_c, frame_c, len_c, seq_c, strb_c;
  logic err, inf;
  logic [3:0] beat2, frame2, len2, seq2, strb2;
  logic err2, inf2;
  int vec = 0;
  int miss = 0;
  int lfsr_bad = 0;
  bit trk = 0;
  logic [15:0] m;
  axis_stream_checker_if #(.WIDTH(32)) s00_axis();
  axis_stream_checker_if #(.WIDTH(32)) s2();
  assign s2.tvalid = s00_axis.tvalid;
  assign s2.tdata  = s00_axis.tdata;
  assign s2.tstrb  = s00_axis.tstrb;
  assign s2.tlast  = s00_axis.tlast;
  always #5 clk = ~clk;
  axis_stream_checker #(.WIDTH(32), .FRAME_LEN(1024), .CNT_W(32), .LFSR_SEED(SEED)) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(s00_axis),
    .cfg_throttle(thr), .cfg_check_seq(seqen), .clear_stats(clr),
    .beat_count(beat_c), .frame_count(frame_c), .len_err_count(len_c),
    .seq_err_count(seq_c), .strb_err_count(strb_c), .err_sticky(err), .in_frame(inf));
  axis_stream_checker #(.WIDTH(32), .FRAME_LEN(1024), .CNT_W(4), .LFSR_SEED(SEED)) dut_sat (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(s2),
    .cfg_throttle(thr), .cfg_check_seq(seqen), .clear_stats(clr),
    .beat_count(beat2), .frame_count(frame2), .len_err_count(len2),
    .seq_err_count(seq2), .strb_err_count(strb2), .err_sticky(err2), .in_frame(inf2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cnts(input string t, input int b, input int f, input int l, input int sq, input int st, input int e);
    chk({t, "_beat"}, beat_c, 32'(b));
    chk({t, "_frame"}, frame_c, 32'(f));
    chk({t, "_len"}, len_c, 32'(l));
    chk({t, "_seq"}, seq_c, 32'(sq));
    chk({t, "_strb"}, strb_c, 32'(st));
    chk({t, "_sticky"}, 32'(err), 32'(e));
  endtask
  // drive from a negedge; returns at the negedge after the accepting posedge
  task automatic beat(input logic [31:0] d, input logic l, input logic [3:0] s);
    bit acc = 0;
    s00_axis.tvalid = 1'b1;
    s00_axis.tdata  = d;
    s00_axis.tlast  = l;
    s00_axis.tstrb  = s;
    for (int n = 0; n < 64 && !acc; n++) begin
      if (trk) begin
        if (s00_axis.tready !== m[0]) lfsr_bad++;
        m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      end
      acc = s00_axis.tready;
      @(negedge clk);
    end
    chk("accept", 32'(acc), 32'd1);
  endtask
  task automatic frame(input int start, input int n, input int lastpos, input int bad);
    for (int i = 0; i < n; i++) beat(i == bad ? 32'hDEAD : 32'(start + i), i == lastpos, 4'hF);
    s00_axis.tvalid = 1'b0;
  endtask
  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask
  initial begin
    s00_axis.tvalid = 1'b0;
    s00_axis.tdata  = '0;
    s00_axis.tlast  = 1'b0;
    s00_axis.tstrb  = 4'hF;
    repeat (3) @(negedge clk);
    cnts("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_tready", 32'(s00_axis.tready), 32'd0);
    chk("reset_in_frame", 32'(inf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_tready", 32'(s00_axis.tready), 32'd1);
    // 1: clean 1024-beat frame
    frame(32'h1000, 1, -1, -1);
    chk("t1_in_frame", 32'(inf), 32'd1);
    frame(32'h1001, 1023, 1022, -1);
    cnts("t1", 1024, 1, 0, 0, 0, 0);
    chk("t1_in_frame_end", 32'(inf), 32'd0);
    chk("sat_beat", 32'(beat2), 32'd15);
    chk("sat_frame", 32'(frame2), 32'd1);
    // 2: short frame then long frame
    frame(32'h1000, 1001, 1000, -1);
    cnts("t2a", 2025, 2, 1, 0, 0, 1);
    frame(32'h1000, 1030, 1029, -1);
    cnts("t2b", 3055, 3, 2, 0, 0, 1);
    // 3: corrupted word 500, with and without continuity checking
    pulse_clr();
    cnts("t3_clr", 0, 0, 0, 0, 0, 0);
    frame(32'h1000, 1024, 1023, 500);
    cnts("t3a", 1024, 1, 0, 2, 0, 1);
    seqen = 1'b0;
    pulse_clr();
    frame(32'h1000, 1024, 1023, 500);
    cnts("t3b", 1024, 1, 0, 0, 0, 0);
    seqen = 1'b1;
    // 4: throttled stream, tready tracked against an LFSR model
    thr = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m = SEED;
    trk = 1;
    for (int f = 0; f < 4; f++) frame(f * 1024, 1024, 1023, -1);
    trk = 0;
    chk("t4_lfsr_tready", 32'(lfsr_bad), 32'd0);
    cnts("t4", 4096, 4, 0, 0, 0, 0);
    // 5: bad strobe, then clear coincident with another bad strobe
    thr = 1'b0;
    @(negedge clk);
    beat(32'h5000, 1'b0, 4'h7);
    s00_axis.tvalid = 1'b0;
    cnts("t5a", 4097, 4, 0, 0, 1, 1);
    chk("t5_tready", 32'(s00_axis.tready), 32'd1);
    clr = 1'b1;
    s00_axis.tvalid = 1'b1;
    s00_axis.tdata  = 32'h5001;
    s00_axis.tstrb  = 4'h7;
    @(negedge clk);
    clr = 1'b0;
    s00_axis.tvalid = 1'b0;
    cnts("t5b", 1, 0, 0, 0, 1, 1);
    chk("t5_in_frame", 32'(inf), 32'd1);
    // 6: reset in the middle of a frame
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame(32'h2000, 300, -1, -1);
    chk("t6_pre_beat", beat_c, 32'd300);
    rst = 1'b1;
    @(negedge clk);
    cnts("t6_rst", 0, 0, 0, 0, 0, 0);
    chk("t6_rst_tready", 32'(s00_axis.tready), 32'd0);
    chk("t6_rst_in_frame", 32'(inf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame(32'h3000, 1024, 1023, -1);
    cnts("t6", 1024, 1, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
